// File: rtl/xtal_mon_pkg.sv
// xtal_mon_pkg: shared FSM encoding, fault codes and the window classifier
// used by the crystal differential-clock monitor.
package xtal_mon_pkg;

  // Monitor sequencing: fill synchronizers, count a window, classify it.
  typedef enum logic [1:0] {
    ST_SETTLE  = 2'b00,
    ST_MEASURE = 2'b01,
    ST_EVAL    = 2'b10
  } state_t;

  // FaultCode encodings reported for each completed window.
  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_SLOW  = 2'b01;
  localparam logic [1:0] FAULT_FAST  = 2'b10;
  localparam logic [1:0] FAULT_COMPL = 2'b11;

  // Reference cycles spent in SETTLE so both synchronizers and the edge stage hold real data.
  localparam int unsigned SETTLE_CYCLES = 3;

  // Window classification, highest priority first: complement, slow/stuck, fast.
  function automatic logic [1:0] classify_window(
    input logic        compl,
    input int unsigned edges,
    input int unsigned min_edges,
    input int unsigned max_edges
  );
    logic [1:0] code;
    if (compl) begin
      code = FAULT_COMPL;
    end else if (edges < min_edges) begin
      code = FAULT_SLOW;
    end else if (edges > max_edges) begin
      code = FAULT_FAST;
    end else begin
      code = FAULT_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/xtal_sync2.sv
// xtal_sync2: two-flop synchronizer bringing one oscillator phase into the
// reference clock domain. Cleared by the monitor's synchronous reset.
module xtal_sync2 (
  input  logic Clock,
  input  logic ResetN,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input; r_meta may go metastable.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/xtal_ddr_monitor.sv
// xtal_ddr_monitor: qualifies the crystal's differential clock pair by
// counting synchronized ClockP rising edges per reference window, watching
// that ClockP/ClockN stay complementary, and raising ClockGood after
// GOOD_WINDOWS consecutive clean windows.
// Optional feature macro: XTAL_MON_STICKY_FAULT_EN adds FaultClear/FaultSticky;
// a sticky fault holds ClockGood low until software clears it.
module xtal_ddr_monitor
  import xtal_mon_pkg::*;
#(
  parameter int unsigned WINDOW       = 1024,
  parameter int unsigned CNT_W        = $clog2(WINDOW) + 1,
  parameter int unsigned MIN_EDGES    = 200,
  parameter int unsigned MAX_EDGES    = 300,
  parameter int unsigned SKEW_TOL     = 2,
  parameter int unsigned GOOD_WINDOWS = 4
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             ClockP,
  input  logic             ClockN,
`ifdef XTAL_MON_STICKY_FAULT_EN
  input  logic             FaultClear,
  output logic             FaultSticky,
`endif
  output logic             ClockGood,
  output logic [1:0]       FaultCode,
  output logic [CNT_W-1:0] EdgeCount,
  output logic             CountValid
);

  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned EQ_W   = $clog2(SKEW_TOL + 2);
  localparam int unsigned PASS_W = $clog2(GOOD_WINDOWS + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  EDGE_MAX    = {CNT_W{1'b1}};
  localparam logic [EQ_W-1:0]   EQ_MAX      = EQ_W'(SKEW_TOL + 1);
  localparam logic [EQ_W-1:0]   EQ_TOL      = EQ_W'(SKEW_TOL);
  localparam logic [PASS_W-1:0] PASS_MAX    = PASS_W'(GOOD_WINDOWS);
  localparam logic [1:0]        SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  // Synchronized phases and the edge-detect stage
  logic w_p_sync;
  logic w_n_sync;
  logic r_p_d;
  logic w_p_rise;

  // Registered state
  state_t           r_state;
  logic [1:0]       r_settle;
  logic [WIN_W-1:0] r_win;
  logic [CNT_W-1:0] r_edge;
  logic [EQ_W-1:0]  r_eq;
  logic             r_compl;
  logic [PASS_W-1:0] r_pass;
  logic             r_good;
  logic [1:0]       r_code;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;

  // Next-state values
  state_t           w_state_nxt;
  logic [1:0]       w_settle_nxt;
  logic [WIN_W-1:0] w_win_nxt;
  logic [CNT_W-1:0] w_edge_nxt;
  logic [EQ_W-1:0]  w_eq_nxt;
  logic             w_compl_nxt;
  logic [PASS_W-1:0] w_pass_nxt;
  logic             w_good_nxt;
  logic [1:0]       w_code_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_valid_nxt;
  logic [1:0]       w_fault;

`ifdef XTAL_MON_STICKY_FAULT_EN
  logic r_sticky;
  logic w_sticky_nxt;
`endif

  xtal_sync2 u_sync_p (
    .Clock  (Clock),
    .ResetN (ResetN),
    .i_d    (ClockP),
    .o_q    (w_p_sync)
  );

  xtal_sync2 u_sync_n (
    .Clock  (Clock),
    .ResetN (ResetN),
    .i_d    (ClockN),
    .o_q    (w_n_sync)
  );

  // Edge-detect stage: delayed copy of synchronized ClockP.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_p_d <= 1'b0;
    end else begin
      r_p_d <= w_p_sync;
    end
  end

  assign w_p_rise = w_p_sync & ~r_p_d;

  // Sequencing, window counters, classification and ClockGood qualification.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_win_nxt    = r_win;
    w_edge_nxt   = r_edge;
    w_eq_nxt     = r_eq;
    w_compl_nxt  = r_compl;
    w_pass_nxt   = r_pass;
    w_code_nxt   = r_code;
    w_count_nxt  = r_count;
    w_valid_nxt  = 1'b0;
    w_fault      = FAULT_NONE;
    w_good_nxt   = r_good;
`ifdef XTAL_MON_STICKY_FAULT_EN
    w_sticky_nxt = r_sticky;
`endif

    case (r_state)
      ST_SETTLE: begin
        // Synchronizer contents are not trusted yet, so nothing is counted.
        w_edge_nxt  = {CNT_W{1'b0}};
        w_eq_nxt    = {EQ_W{1'b0}};
        w_compl_nxt = 1'b0;
        w_win_nxt   = {WIN_W{1'b0}};
        if (r_settle == SETTLE_LAST) begin
          w_state_nxt  = ST_MEASURE;
          w_settle_nxt = 2'b00;
        end else begin
          w_settle_nxt = r_settle + 2'b01;
        end
      end

      ST_MEASURE: begin
        if (w_p_rise && (r_edge != EDGE_MAX)) begin
          w_edge_nxt = r_edge + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_edge_nxt = r_edge;
        end

        // Run length of samples where the pair is not complementary.
        if (w_p_sync == w_n_sync) begin
          if (r_eq == EQ_MAX) begin
            w_eq_nxt = r_eq;
          end else begin
            w_eq_nxt = r_eq + {{(EQ_W-1){1'b0}}, 1'b1};
          end
          if (r_eq >= EQ_TOL) begin
            w_compl_nxt = 1'b1;
          end else begin
            w_compl_nxt = r_compl;
          end
        end else begin
          w_eq_nxt    = {EQ_W{1'b0}};
          w_compl_nxt = r_compl;
        end

        if (r_win == WIN_LAST) begin
          w_state_nxt = ST_EVAL;
          w_win_nxt   = {WIN_W{1'b0}};
        end else begin
          w_win_nxt = r_win + {{(WIN_W-1){1'b0}}, 1'b1};
        end
      end

      ST_EVAL: begin
        w_fault     = classify_window(r_compl, 32'(r_edge), MIN_EDGES, MAX_EDGES);
        w_code_nxt  = w_fault;
        w_count_nxt = r_edge;
        w_valid_nxt = 1'b1;
        if (w_fault == FAULT_NONE) begin
          if (r_pass == PASS_MAX) begin
            w_pass_nxt = r_pass;
          end else begin
            w_pass_nxt = r_pass + {{(PASS_W-1){1'b0}}, 1'b1};
          end
        end else begin
          w_pass_nxt = {PASS_W{1'b0}};
        end
        // A rise seen during EVAL belongs to the window that starts now.
        w_edge_nxt  = {{(CNT_W-1){1'b0}}, w_p_rise};
        w_eq_nxt    = {EQ_W{1'b0}};
        w_compl_nxt = 1'b0;
        w_win_nxt   = {WIN_W{1'b0}};
        w_state_nxt = ST_MEASURE;
      end

      default: begin
        w_state_nxt  = ST_SETTLE;
        w_settle_nxt = 2'b00;
      end
    endcase

`ifdef XTAL_MON_STICKY_FAULT_EN
    // A faulting EVAL sets the sticky flag even if FaultClear is high.
    if ((r_state == ST_EVAL) && (w_fault != FAULT_NONE)) begin
      w_sticky_nxt = 1'b1;
    end else if (FaultClear) begin
      w_sticky_nxt = 1'b0;
    end else begin
      w_sticky_nxt = r_sticky;
    end

    if (r_state == ST_EVAL) begin
      w_good_nxt = (w_pass_nxt == PASS_MAX) && !w_sticky_nxt;
    end else begin
      w_good_nxt = r_good && !w_sticky_nxt;
    end
`else
    if (r_state == ST_EVAL) begin
      w_good_nxt = (w_pass_nxt == PASS_MAX);
    end else begin
      w_good_nxt = r_good;
    end
`endif
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_state  <= ST_SETTLE;
      r_settle <= 2'b00;
      r_win    <= {WIN_W{1'b0}};
      r_edge   <= {CNT_W{1'b0}};
      r_eq     <= {EQ_W{1'b0}};
      r_compl  <= 1'b0;
      r_pass   <= {PASS_W{1'b0}};
      r_good   <= 1'b0;
      r_code   <= FAULT_NONE;
      r_count  <= {CNT_W{1'b0}};
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_win    <= w_win_nxt;
      r_edge   <= w_edge_nxt;
      r_eq     <= w_eq_nxt;
      r_compl  <= w_compl_nxt;
      r_pass   <= w_pass_nxt;
      r_good   <= w_good_nxt;
      r_code   <= w_code_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

`ifdef XTAL_MON_STICKY_FAULT_EN
  // Sticky fault flag register.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_sticky <= 1'b0;
    end else begin
      r_sticky <= w_sticky_nxt;
    end
  end

  assign FaultSticky = r_sticky;
`endif

  assign ClockGood  = r_good;
  assign FaultCode  = r_code;
  assign EdgeCount  = r_count;
  assign CountValid = r_valid;

endmodule

// File: tb/tb_xtal_ddr_monitor.sv
// tb_xtal_ddr_monitor: directed test of the crystal differential-clock monitor.
module tb_xtal_ddr_monitor;
  import xtal_mon_pkg::*;

  localparam int unsigned CNT_W = 11;

  logic             Clock;
  logic             ResetN;
  logic             ClockP;
  logic             ClockN;
  logic             ClockGood;
  logic [1:0]       FaultCode;
  logic [CNT_W-1:0] EdgeCount;
  logic             CountValid;
`ifdef XTAL_MON_STICKY_FAULT_EN
  logic             FaultClear;
  logic             FaultSticky;
`endif

  typedef enum int {M_GOOD, M_FAST, M_STUCK} mode_t;
  mode_t mode;
  logic  force_eq;

  int checks;
  int errors;

  xtal_ddr_monitor dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .ClockP     (ClockP),
    .ClockN     (ClockN),
`ifdef XTAL_MON_STICKY_FAULT_EN
    .FaultClear (FaultClear),
    .FaultSticky(FaultSticky),
`endif
    .ClockGood  (ClockGood),
    .FaultCode  (FaultCode),
    .EdgeCount  (EdgeCount),
    .CountValid (CountValid)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Oscillator model: patterns advance on the falling reference edge.
  initial begin
    int ph;
    ph = 0;
    ClockP = 1'b0;
    ClockN = 1'b1;
    forever begin
      @(negedge Clock);
      case (mode)
        M_GOOD:  ClockP = ((ph % 4) < 2) ? 1'b1 : 1'b0;
        M_FAST:  ClockP = ((ph % 5) == 0 || (ph % 5) == 2 || (ph % 5) == 3) ? 1'b1 : 1'b0;
        default: ClockP = 1'b0;
      endcase
      ClockN = (mode == M_GOOD && force_eq) ? ClockP : ~ClockP;
      ph++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs,
                             input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Counts falling edges until CountValid is seen, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (CountValid !== 1'b1 && n <= 1100);
  endtask

  task automatic window(input string tag, input int exp_n, input logic [1:0] code,
                        input int lo, input int hi, input logic good);
    int n;
    wait_valid(n);
    check({tag, "/latency"}, 32'(n), 32'(exp_n));
    check({tag, "/code"}, 32'(FaultCode), 32'(code));
    check_range({tag, "/count"}, 32'(EdgeCount), 32'(lo), 32'(hi));
    check({tag, "/good"}, 32'(ClockGood), 32'(good));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ResetN   = 1'b0;
    mode     = M_GOOD;
    force_eq = 1'b0;
`ifdef XTAL_MON_STICKY_FAULT_EN
    FaultClear = 1'b0;
`endif
    repeat (3) @(negedge Clock);
    check("rst/good",  32'(ClockGood),  32'(0));
    check("rst/code",  32'(FaultCode),  32'(0));
    check("rst/count", 32'(EdgeCount),  32'(0));
    check("rst/valid", 32'(CountValid), 32'(0));

    // Good 256-edge oscillator: qualifies after four windows.
    ResetN = 1'b1;
    window("w1", 1028, FAULT_NONE, 256, 256, 1'b0);
    @(negedge Clock);
    check("w1/pulse", 32'(CountValid), 32'(0));
    window("w2", 1024, FAULT_NONE, 256, 257, 1'b0);
    window("w3", 1025, FAULT_NONE, 256, 257, 1'b0);
    window("w4", 1025, FAULT_NONE, 256, 257, 1'b1);

    // Fast oscillator drops ClockGood in its EVAL cycle.
    mode = M_FAST;
    window("w5_fast", 1025, FAULT_FAST, 400, 420, 1'b0);

    // Stuck pair: slow fault, zero edges once the pipeline drains.
    mode = M_STUCK;
    window("w6_stuck", 1025, FAULT_SLOW, 0, 3, 1'b0);
    window("w7_stuck", 1025, FAULT_SLOW, 0, 0, 1'b0);

    // Back to good, then a 4-sample complement violation mid-window.
    mode = M_GOOD;
    window("w8", 1025, FAULT_NONE, 254, 257, 1'b0);
    repeat (500) @(negedge Clock);
    force_eq = 1'b1;
    repeat (4) @(negedge Clock);
    force_eq = 1'b0;
    window("w9_compl", 521, FAULT_COMPL, 255, 257, 1'b0);
    window("w10", 1025, FAULT_NONE, 255, 257, 1'b0);
    window("w11", 1025, FAULT_NONE, 255, 257, 1'b0);
    window("w12", 1025, FAULT_NONE, 255, 257, 1'b0);

    // One-cycle reset mid-window with pass count at 3.
    repeat (500) @(negedge Clock);
    ResetN = 1'b0;
    @(negedge Clock);
    check("mrst/valid", 32'(CountValid), 32'(0));
    check("mrst/count", 32'(EdgeCount),  32'(0));
    check("mrst/code",  32'(FaultCode),  32'(0));
    check("mrst/good",  32'(ClockGood),  32'(0));
    ResetN = 1'b1;
    window("w13", 1028, FAULT_NONE, 256, 256, 1'b0);
    window("w14", 1025, FAULT_NONE, 256, 257, 1'b0);
    window("w15", 1025, FAULT_NONE, 256, 257, 1'b0);
    window("w16", 1025, FAULT_NONE, 256, 257, 1'b1);

`ifdef XTAL_MON_STICKY_FAULT_EN
    check("sticky/init", 32'(FaultSticky), 32'(0));
    mode = M_STUCK;
    window("w17_stuck", 1025, FAULT_SLOW, 0, 3, 1'b0);
    check("sticky/set", 32'(FaultSticky), 32'(1));
    mode = M_GOOD;
    window("w18", 1025, FAULT_NONE, 254, 257, 1'b0);
    window("w19", 1025, FAULT_NONE, 255, 257, 1'b0);
    window("w20", 1025, FAULT_NONE, 255, 257, 1'b0);
    window("w21", 1025, FAULT_NONE, 255, 257, 1'b0);
    check("sticky/hold", 32'(FaultSticky), 32'(1));
    FaultClear = 1'b1;
    @(negedge Clock);
    FaultClear = 1'b0;
    check("sticky/clear", 32'(FaultSticky), 32'(0));
    check("sticky/good0", 32'(ClockGood),   32'(0));
    window("w22", 1024, FAULT_NONE, 255, 257, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
